alu_wb_stage: RTL

- Downstream stage of the 32-bit ALU. Captures Alures/Zero/Neg/ovfalu plus destination info into a 2-entry in-order skid buffer, then hands entries to register-file writeback with a valid/ready handshake.
- Keeps the architectural N/Z/V flag register and a sticky overflow bit, both updated when an entry retires.
- Decouples ALU timing from writeback stalls; no combinational path from out_ready to in_ready.

---
 rtl/alu_wb_stage_if.sv | 31 +++
 rtl/alu_wb_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage_if.sv
// Handshake bundle between the ALU result stage and register-file writeback.
// The stage consumes in_* and produces out_* through the slave modport.
interface alu_wb_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_res;
    logic          in_zero;
    logic          in_neg;
    logic          in_ovf;
    logic [RW-1:0] in_rd;
    logic          in_we;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_res;
    logic [RW-1:0] out_rd;
    logic          out_we;

    modport master (
        output in_valid, in_res, in_zero, in_neg, in_ovf, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_res, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_res, in_zero, in_neg, in_ovf, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_res, out_rd, out_we
    );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry in-order skid buffer, N/Z/V flags and sticky overflow.
// Optional feature macro ALU_WB_OVF_TRAP_EN: suppresses writes of overflowing results and pulses ovf_trap.
module alu_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_wb_stage_if.slave       bus,
    input  logic                flush,
    output logic [2:0]          flags,
    output logic                ovf_sticky,
    input  logic                ovf_clr,
    output logic                ovf_trap
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    count_p0;
    logic          vld_p0;

    logic [DW-1:0] res_p0;
    logic          zero_p0;
    logic          neg_p0;
    logic          ovf_p0;
    logic [RW-1:0] rd_p0;
    logic          we_p0;

    logic [DW-1:0] res_p1;
    logic          zero_p1;
    logic          neg_p1;
    logic          ovf_p1;
    logic [RW-1:0] rd_p1;
    logic          we_p1;

    logic push;
    logic pop;
    logic retire;
    logic load_head_in;
    logic load_head_p1;
    logic load_tail_in;
    logic clr_head_we;

    // in_ready depends only on the registered occupancy, so out_ready never reaches it.
    assign vld_p0       = (count_p0 != EMPTY);
    assign bus.in_ready = (count_p0 != FULL);
    assign bus.out_valid = vld_p0;

    assign push   = bus.in_valid & bus.in_ready;
    assign pop    = vld_p0 & bus.out_ready;
    assign retire = pop & ~flush;

    assign load_head_in = ~flush & push & ((count_p0 == EMPTY) | ((count_p0 == ONE) & pop));
    assign load_head_p1 = ~flush & pop & (count_p0 == FULL);
    assign load_tail_in = ~flush & push & ~pop & (count_p0 == ONE);
    assign clr_head_we  = flush | ((count_p0 == ONE) & pop & ~push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p0 <= EMPTY;
        end else if (flush) begin
            count_p0 <= EMPTY;
        end else begin
            case (count_p0)
                EMPTY: if (push) count_p0 <= ONE;
                ONE: begin
                    if (push && !pop)      count_p0 <= FULL;
                    else if (pop && !push) count_p0 <= EMPTY;
                end
                FULL: if (pop) count_p0 <= ONE;
                default: count_p0 <= EMPTY;
            endcase
        end
    end

    // Stage 0: head entry, drives out_* directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p0  <= '0;
            zero_p0 <= 1'b0;
            neg_p0  <= 1'b0;
            ovf_p0  <= 1'b0;
            rd_p0   <= '0;
            we_p0   <= 1'b0;
        end else if (load_head_in) begin
            res_p0  <= bus.in_res;
            zero_p0 <= bus.in_zero;
            neg_p0  <= bus.in_neg;
            ovf_p0  <= bus.in_ovf;
            rd_p0   <= bus.in_rd;
            we_p0   <= bus.in_we;
        end else if (load_head_p1) begin
            res_p0  <= res_p1;
            zero_p0 <= zero_p1;
            neg_p0  <= neg_p1;
            ovf_p0  <= ovf_p1;
            rd_p0   <= rd_p1;
            we_p0   <= we_p1;
        end else if (clr_head_we) begin
            we_p0   <= 1'b0;
        end
    end

    // Stage 1: skid slot, only meaningful while count is FULL
    always_ff @(posedge clk) begin
        if (load_tail_in) begin
            res_p1  <= bus.in_res;
            zero_p1 <= bus.in_zero;
            neg_p1  <= bus.in_neg;
            ovf_p1  <= bus.in_ovf;
            rd_p1   <= bus.in_rd;
            we_p1   <= bus.in_we;
        end
    end

    assign bus.out_res = res_p0;
    assign bus.out_rd  = rd_p0;

    // Architectural state changes only when the head actually retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= 3'b000;
            ovf_sticky <= 1'b0;
        end else begin
            if (retire) flags <= {neg_p0, zero_p0, ovf_p0};
            if (retire && ovf_p0) ovf_sticky <= 1'b1;
            else if (ovf_clr)     ovf_sticky <= 1'b0;
        end
    end

`ifdef ALU_WB_OVF_TRAP_EN
    logic trap_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_p1 <= 1'b0;
        else        trap_p1 <= retire & ovf_p0;
    end

    assign ovf_trap   = trap_p1;
    assign bus.out_we = we_p0 & ~ovf_p0;
`else
    assign ovf_trap   = 1'b0;
    assign bus.out_we = we_p0;
`endif

    a_count_legal: assert property (@(posedge clk) disable iff (!rst_n) count_p0 != 2'd3);
endmodule
